// File: rtl/sobol_seq_ctrl_if.sv
// Handshake bundle between the Sobol batch controller,
// its point generator and the downstream point consumer.
interface sobol_seq_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PT_W  = 128
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_restart;
  logic             gen_clr;
  logic             gen_adv;
  logic [PT_W-1:0]  gen_res;
  logic             pt_valid;
  logic             pt_ready;
  logic [PT_W-1:0]  pt_data;
  logic             pt_last;
  logic [CNT_W-1:0] pt_idx;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid,
    output cmd_len,
    output cmd_restart,
    output gen_res,
    output pt_ready,
    input  cmd_ready,
    input  gen_clr,
    input  gen_adv,
    input  pt_valid,
    input  pt_data,
    input  pt_last,
    input  pt_idx,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_len,
    input  cmd_restart,
    input  gen_res,
    input  pt_ready,
    output cmd_ready,
    output gen_clr,
    output gen_adv,
    output pt_valid,
    output pt_data,
    output pt_last,
    output pt_idx,
    output busy,
    output done
  );
endinterface

// File: rtl/sobol_seq_ctrl.sv
// Batch controller for a 4-D Sobol point generator with a 2-entry output FIFO.
// Define SOBOL_SKIP_EN to discard the all-zero point 0 after every restart.
module sobol_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int PT_W  = 128
) (
  input  logic            clk,
  input  logic            rst,
  sobol_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SKIP,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] acc_q;
  logic             infl_q;
  logic [PT_W-1:0]  mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             clr_q;
`ifdef SOBOL_SKIP_EN
  logic             skip_ph_q;
`endif

  logic       accept;
  logic       pop;
  logic       adv;
  logic [1:0] cnt_d;

  assign accept = bus.cmd_valid && cmd_ready_q;
  assign pop    = (cnt_q != 2'd0) && bus.pt_ready;

  // Occupancy after this edge; a slot freed by this cycle's read is reusable.
  assign cnt_d = cnt_q - {1'b0, pop} + {1'b0, infl_q};

  assign adv = (state_q == RUN)
            && (issued_q != len_q)
            && (cnt_d < 2'd2);

`ifdef SOBOL_SKIP_EN
  assign bus.gen_adv = adv
                    || ((state_q == SKIP) && !skip_ph_q);
`else
  assign bus.gen_adv = adv;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.gen_clr   = clr_q;
  assign bus.pt_valid  = (cnt_q != 2'd0);
  assign bus.pt_data   = mem_q[rd_ptr_q];
  assign bus.pt_idx    = acc_q;
  assign bus.pt_last   = (cnt_q != 2'd0)
                      && (acc_q == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      acc_q       <= '0;
      infl_q      <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_q       <= 1'b0;
`ifdef SOBOL_SKIP_EN
      skip_ph_q   <= 1'b0;
`endif
    end else begin
      infl_q <= adv;
      cnt_q  <= cnt_d;
      if (adv) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      if (infl_q) begin
        mem_q[wr_ptr_q] <= bus.gen_res;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        acc_q    <= acc_q + CNT_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            len_q       <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_restart) begin
              state_q <= CLR;
              clr_q   <= 1'b1;
            end else if (bus.cmd_len != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        CLR: begin
          clr_q <= 1'b0;
`ifdef SOBOL_SKIP_EN
          state_q <= SKIP;
`else
          if (len_q != '0) begin
            state_q <= RUN;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`endif
        end
        SKIP: begin
`ifdef SOBOL_SKIP_EN
          // Phase 0 strobes point 0; phase 1 lets it go by unstored.
          skip_ph_q <= ~skip_ph_q;
          if (skip_ph_q) begin
            if (len_q != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
`else
          state_q <= IDLE;
`endif
        end
        RUN: begin
          if (issued_q == len_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == 2'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          issued_q    <= '0;
          acc_q       <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Bench for sobol_seq_ctrl: generator stub, point scoreboard,
// table-driven batches, reset abort, random batches, max-length batch.
`timescale 1ns/1ps
module tb_sobol_seq_ctrl;
  localparam int CNT_W = 16;
  localparam int PT_W  = 128;
`ifdef SOBOL_SKIP_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  typedef struct {
    int len;
    bit restart;
    int mode;
    int exp_adv;
    int exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobol_seq_ctrl_if #(.CNT_W(CNT_W), .PT_W(PT_W)) bus ();

  sobol_seq_ctrl #(.CNT_W(CNT_W), .PT_W(PT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int gen_g      = 0;
  int model_g    = 0;
  int ready_mode = 0;
  logic prev_adv = 1'b0;
  logic prev_clr = 1'b0;

  logic             s_valid, s_ready, s_last;
  logic             s_adv, s_clr, s_done;
  logic             s_busy, s_cmd_ready;
  logic [PT_W-1:0]  s_data;
  logic [CNT_W-1:0] s_idx;

  // Reference point i of the sequence; point 0 is all zero.
  function automatic logic [PT_W-1:0] pt(int i);
    logic [31:0] u;
    u = 32'(i);
    return {u * 32'h9E3779B1, u * 32'h85EBCA6B,
            u * 32'hC2B2AE35, u * 32'h27D4EB2F};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pt(string name, logic [PT_W-1:0] act,
                        logic [PT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: generator stub answers last cycle's strobes,
  // consumer picks pt_ready, then all outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (prev_clr) gen_g = 0;
    if (prev_adv) begin
      bus.gen_res = pt(gen_g);
      gen_g++;
    end else begin
      bus.gen_res = {$urandom, $urandom, $urandom, $urandom};
    end
    if (ready_mode == 0)      bus.pt_ready = 1'b1;
    else if (ready_mode == 1) bus.pt_ready = (cyc % 2 == 0);
    else if (ready_mode == 2) bus.pt_ready = 1'($urandom_range(0, 1));
    else                      bus.pt_ready = 1'b0;
    #1;
    s_valid     = bus.pt_valid;
    s_ready     = bus.pt_ready;
    s_last      = bus.pt_last;
    s_data      = bus.pt_data;
    s_idx       = bus.pt_idx;
    s_adv       = bus.gen_adv;
    s_clr       = bus.gen_clr;
    s_done      = bus.done;
    s_busy      = bus.busy;
    s_cmd_ready = bus.cmd_ready;
    prev_adv    = s_adv;
    prev_clr    = s_clr;
    cyc++;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " cmd_ready"}, int'(s_cmd_ready), 1);
    chk({tag, " busy"}, int'(s_busy), 0);
    chk({tag, " done"}, int'(s_done), 0);
    chk({tag, " gen_clr"}, int'(s_clr), 0);
    chk({tag, " gen_adv"}, int'(s_adv), 0);
    chk({tag, " pt_valid"}, int'(s_valid), 0);
    chk({tag, " pt_last"}, int'(s_last), 0);
    chk({tag, " pt_idx"}, int'(s_idx), 0);
    chk_pt({tag, " pt_data"}, s_data, '0);
  endtask

  task automatic run_batch(int len, bit restart, int mode,
                           int exp_adv, int exp_first, string tag);
    int nadv, nrun, nclr, ntr, ndone, maxout, budget, t;
    int frun, lrun, fvalid, ltr, dcyc;
    logic stalled;
    logic [PT_W-1:0] hd;
    logic [CNT_W-1:0] hi;
    logic hl;
    nadv = 0; nrun = 0; nclr = 0; ntr = 0; ndone = 0; maxout = 0;
    frun = -1; lrun = -1; fvalid = -1; ltr = -1; dcyc = -1;
    stalled = 1'b0; hd = '0; hi = '0; hl = 1'b0;
    ready_mode = mode;
    budget = (mode == 0 ? 2 : 4) * len + 40;
    chk({tag, " idle cmd_ready"}, int'(s_cmd_ready), 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_len     = CNT_W'(len);
    bus.cmd_restart = restart;
    tick();
    bus.cmd_valid   = 1'b0;
    bus.cmd_len     = CNT_W'($urandom);
    bus.cmd_restart = 1'($urandom);
    chk({tag, " busy cmd_ready"}, int'(s_cmd_ready), 0);
    chk({tag, " busy flag"}, int'(s_busy), 1);
    t = 0;
    while (dcyc < 0 && t < budget) begin
      if (nrun - ntr > maxout) maxout = nrun - ntr;
      if (s_clr) nclr++;
      if (s_adv) begin
        nadv++;
        if (!(restart && SKIP == 1 && nadv == 1)) begin
          nrun++;
          if (frun < 0) frun = cyc;
          lrun = cyc;
        end
      end
      if (stalled) begin
        chk({tag, " hold valid"}, int'(s_valid), 1);
        chk_pt({tag, " hold data"}, s_data, hd);
        chk({tag, " hold idx"}, int'(s_idx), int'(hi));
        chk({tag, " hold last"}, int'(s_last), int'(hl));
      end
      if (s_valid && fvalid < 0) fvalid = cyc;
      if (s_valid && s_ready) begin
        chk_pt({tag, " data"}, s_data, pt(exp_first + ntr));
        chk({tag, " idx"}, int'(s_idx), ntr);
        chk({tag, " last"}, int'(s_last), int'(ntr == len - 1));
        ntr++;
        ltr = cyc;
      end
      stalled = s_valid && !s_ready;
      hd = s_data; hi = s_idx; hl = s_last;
      if (s_done) begin
        ndone++;
        dcyc = cyc;
      end else begin
        tick();
        t++;
      end
    end
    chk({tag, " done seen"}, int'(dcyc >= 0), 1);
    if (dcyc < 0) begin
      rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    end
    chk({tag, " clr count"}, nclr, restart ? 1 : 0);
    chk({tag, " adv count"}, nadv, exp_adv);
    chk({tag, " transfers"}, ntr, len);
    chk({tag, " outstanding<=2"}, int'(maxout <= 2), 1);
    if (len > 0) begin
      chk({tag, " first latency"}, fvalid - frun, 2);
      chk({tag, " done gap"}, dcyc - ltr, 1);
      if (mode == 0) chk({tag, " adv consecutive"}, lrun - frun + 1, len);
    end else begin
      chk({tag, " no pt_valid"}, fvalid, -1);
    end
    tick();
    if (s_done) ndone++;
    chk({tag, " ready after done"}, int'(s_cmd_ready), 1);
    chk({tag, " busy after done"}, int'(s_busy), 0);
    tick();
    if (s_done) ndone++;
    chk({tag, " done pulses"}, ndone, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   len, w;
    bit   rs;
    bus.cmd_valid   = 1'b0;
    bus.cmd_len     = '0;
    bus.cmd_restart = 1'b0;
    bus.gen_res     = '0;
    bus.pt_ready    = 1'b0;

    tbl[0] = '{4, 1'b1, 0, 4 + SKIP, SKIP};
    tbl[1] = '{8, 1'b0, 1, 8,        SKIP + 4};
    tbl[2] = '{0, 1'b0, 0, 0,        SKIP + 12};
    tbl[3] = '{3, 1'b1, 0, 3 + SKIP, SKIP};
    tbl[4] = '{3, 1'b0, 0, 3,        SKIP + 3};
    tbl[5] = '{1, 1'b0, 2, 1,        SKIP + 6};
    tbl[6] = '{0, 1'b1, 0, SKIP,     SKIP};
    tbl[7] = '{2, 1'b1, 1, 2 + SKIP, SKIP};

    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset("in reset");
    rst = 1'b0;
    tick();
    chk_reset("after reset");

    for (int i = 0; i < 8; i++) begin
      run_batch(tbl[i].len, tbl[i].restart, tbl[i].mode,
                tbl[i].exp_adv, tbl[i].exp_first,
                $sformatf("vec%0d", i));
      model_g = tbl[i].exp_first + tbl[i].len;
    end

    // Abort a batch while one point sits in the FIFO.
    ready_mode      = 3;
    bus.cmd_valid   = 1'b1;
    bus.cmd_len     = CNT_W'(6);
    bus.cmd_restart = 1'b1;
    tick();
    bus.cmd_valid   = 1'b0;
    w = 0;
    while (!s_valid && w < 20) begin
      tick();
      w++;
    end
    chk("abort point pending", int'(s_valid), 1);
    rst = 1'b1;
    tick();
    chk_reset("abort reset");
    rst = 1'b0;
    tick();
    chk_reset("abort after");
    model_g = SKIP + 2;
    run_batch(2, 1'b0, 0, 2, model_g, "post-abort");
    model_g += 2;

    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(0, 9);
      rs  = ($urandom_range(0, 3) == 0);
      if (rs) model_g = SKIP;
      run_batch(len, rs, $urandom_range(0, 2),
                len + (rs ? SKIP : 0), model_g,
                $sformatf("rand%0d", i));
      model_g += len;
    end

    run_batch(65535, 1'b0, 0, 65535, model_g, "maxlen");
    model_g += 65535;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sobol_seq_ctrl.md
SOBOL_SEQ_CTRL -- requirements
Module: sobol_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the point count and index.
REQ-002 SHALL have parameter PT_W, default 128, the width of one 4-dimension point, packed {res3,res2,res1,res0}.
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  batch command present.
REQ-006 cmd_ready  output  1  controller can accept a command; high only in IDLE.
REQ-007 cmd_len  input  CNT_W  number of points requested; 0 is legal.
REQ-008 cmd_restart  input  1  when 1, rewind the generator to sequence index 0 before the batch.
REQ-009 gen_clr  output  1  one-cycle generator clear pulse.
REQ-010 gen_adv  output  1  generator advance strobe, one point per strobe.
REQ-011 gen_res  input  PT_W  generator point; valid exactly one cycle after the cycle in which gen_adv is high.
REQ-012 pt_valid  output  1  output point available.
REQ-013 pt_ready  input  1  consumer accepts the point.
REQ-014 pt_data  output  PT_W  output point.
REQ-015 pt_last  output  1  pt_data is the final point of the batch.
REQ-016 pt_idx  output  CNT_W  batch-relative index of pt_data, 0-based.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when the batch completes.

Function
REQ-019 SHALL implement the FSM states IDLE, CLR, SKIP, RUN, DRAIN and DONE.
REQ-020 IDLE: accepting cmd_valid&&cmd_ready latches cmd_len and cmd_restart; next state is CLR if restart=1, else RUN if len>0, else DONE.
REQ-021 CLR: gen_clr=1 for exactly 1 cycle; next state is SKIP (see REQ-034), else RUN if len>0, else DONE.
REQ-022 RUN: gen_adv=1 when issued<len and (FIFO occupancy + in-flight)<2; an in-flight point is one whose gen_adv was high in the previous cycle.
REQ-023 gen_res SHALL be written into a 2-entry output FIFO on the clock edge ending the cycle after gen_adv; the FIFO is never overwritten or overflowed.
REQ-024 Latency: first pt_valid SHALL rise 2 cycles after the first gen_adv cycle; the block sustains 1 point/cycle while pt_ready is held at 1.
REQ-025 pt_valid/pt_data/pt_last/pt_idx SHALL hold stable while pt_valid=1 and pt_ready=0.
REQ-026 A transfer occurs on pt_valid&&pt_ready; a simultaneous FIFO write and read in the same cycle is supported and leaves the occupancy unchanged.
REQ-027 RUN goes to DRAIN when issued==len; DRAIN goes to DONE when the FIFO is empty and nothing is in flight.
REQ-028 DONE: done=1 for 1 cycle, then the FSM returns to IDLE; cmd_ready is 0 during DONE.
REQ-029 len=0: no gen_adv and no pt_valid; done pulses exactly once.
REQ-030 Without restart, the generator continues from its current index across batches, while pt_idx restarts at 0 for each batch.
REQ-031 The issued and accepted counters SHALL be CNT_W wide; len=2^CNT_W-1 completes without counter wrap.

Reset
REQ-032 While rst=1, the FSM goes to IDLE, the FIFO is emptied, all counters are cleared and in-flight tracking is discarded.
REQ-033 During and after reset: cmd_ready=1, busy=0, done=0, gen_clr=0, gen_adv=0, pt_valid=0, pt_last=0, pt_idx=0, pt_data=0; reset asserted mid-batch aborts the batch with no done pulse.

Configuration
REQ-034 Macro SOBOL_SKIP_EN defined: after CLR, the SKIP state asserts gen_adv for 1 cycle and waits 1 cycle; the all-zero point 0 is discarded and not counted; the FSM then goes to RUN or DONE.
REQ-035 Macro SOBOL_SKIP_EN undefined: the SKIP state is never entered, and the point at generator index 0 is delivered as pt_idx 0.

Verification
REQ-036 Reset, then cmd_len=4, restart=1, pt_ready=1 -> gen_clr pulse; 4 gen_adv in consecutive cycles; 4 points with pt_idx 0..3; pt_last on idx 3; done 1 cycle after last transfer.
REQ-037 cmd_len=8, pt_ready toggled 1/0 each cycle -> no point lost or duplicated; data stable during stalls; at most 2 outstanding (FIFO + in-flight).
REQ-038 cmd_len=0 with restart=0 -> no gen_adv, no pt_valid, done pulses exactly once, cmd_ready returns to 1.
REQ-039 Two back-to-back batches with len=3 and restart=0 -> second batch data continues the generator sequence (points 3..5), pt_idx 0..2.
REQ-040 rst asserted while 1 point is in the FIFO mid-batch -> all outputs at reset values next cycle, no done; a new cmd_len=2 batch runs normally.
REQ-041 SOBOL_SKIP_EN defined, restart=1, len=2 -> 3 gen_adv strobes; first point delivered equals generator point 1.
